dpu_seq_ctrl: RTL and testbench
===============================

Name: dpu_seq_ctrl

Overview:
Option sequencer for the DPU datapath. It holds a small per-state table of dwell delays and accumulator-clear flags, programmed over a config strobe. On start it steps the DPU option index through states 0..num_states-1 for a programmed number of passes. The option index drives the DPU mode/immediate memory select, and acc_clear drives the accumulator reset. It sits between the resource instruction decoder and the DPU core.

Parameters:
NUM_STATES, 4, number of table entries / DPU options
DELAY_WIDTH, 8, width of per-state dwell delay
ITER_WIDTH, 8, width of repeat count
OPT_WIDTH, $clog2(NUM_STATES), width of option index (derived localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  table write strobe
cfg_addr  in  OPT_WIDTH  table entry written
cfg_delay  in  DELAY_WIDTH  extra dwell cycles for entry
cfg_clr  in  1  pulse acc_clear on entry to this state
cfg_err  out  1  one-cycle pulse: write rejected (busy)
start  in  1  begin sequence (sampled in IDLE only)
start_len  in  OPT_WIDTH+1  number of active states
start_iter  in  ITER_WIDTH  extra passes (N → N+1 passes)
abort  in  1  synchronous abort
busy  out  1  high in RUN
option  out  OPT_WIDTH  current DPU option index
option_valid  out  1  option drives datapath this cycle
acc_clear  out  1  accumulator clear pulse
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is updated on posedge clk.
- Reset values: busy, option, option_valid, acc_clear, done and cfg_err are all 0. The table resets to delay=0, clr=0. The FSM resets to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_valid writes table[cfg_addr] at the clock edge.
  - start=1 latches len and iter and goes to RUN next cycle, with option=0, dwell counter=table[0].delay, and acc_clear=table[0].clr.
  - Latency: start at edge E, so option_valid=1 in the cycle after E.
- Length rules: start_len=0 is treated as 1. start_len>NUM_STATES is clamped to NUM_STATES.
- RUN, dwell: each state s lasts table[s].delay+1 cycles. The counter decrements each cycle. Advance occurs when counter==0.
- RUN, advance:
  - If s<len-1, go to s+1 and load its delay. acc_clear=table[s+1].clr in the first cycle of the new state only.
  - If s==len-1 and the remaining-iteration count>0, decrement the count and wrap to state 0. acc_clear follows table[0].clr.
  - If s==len-1 and the count==0, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. option_valid=0 in DONE. option holds its last value.
- abort in RUN: go to IDLE next cycle. No done pulse. option resets to 0. abort in IDLE or DONE is ignored.
- Simultaneous abort and advance: abort wins.
- cfg_valid in RUN or DONE: the write is dropped and cfg_err pulses in the next cycle. The table is never modified mid-sequence.
- start outside IDLE: ignored. A start in the DONE cycle is not accepted.
- Simultaneous cfg_valid and start in IDLE: the write is performed first. If cfg_addr==0, the entry-0 delay/clr used for the first state is the newly written value.
- Counter width: a delay of 2^DELAY_WIDTH-1 is legal. The counter never underflows.
- Reset asserted mid-RUN: immediate return to reset values. The table is cleared.

Optional Feature:
DPU_SEQ_PERF_EN
- Defined: adds output perf_cycles[15:0], counting cycles with busy=1.
  - Clears on each accepted start.
  - Saturates at 16'hFFFF.
  - Holds its value after done or abort.
  - Reset 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Single pass: table delays {2,0,1,3}, clr {1,0,0,0}; start len=3, iter=0. Required response:
  - option sequence 0,0,0,1,2,2 over 6 cycles
  - acc_clear high only in cycle 1
  - done in cycle 7
  - busy low on the done cycle
- Repeat: same table, iter=1. Required response:
  - 12 option_valid cycles
  - acc_clear pulses at cycles 1 and 7
  - single done pulse
- Clamp and zero: len=0 gives one state (option 0, 3 cycles) then done. len=7 with NUM_STATES=4 runs 4 states.
- Abort: abort in the 2nd cycle of state 1. Next cycle: IDLE, busy=0, option=0, no done. A new start is accepted afterwards.
- Config rejection: cfg_valid addr=1 delay=5 while busy. cfg_err pulses. Entry 1 keeps delay 0, verified on the next run.
- Max delay and reset: delay[0]=255, len=1. State 0 lasts 256 cycles. A separate run with rst_n asserted mid-dwell clears all outputs asynchronously and returns to IDLE.

Source files
------------

// File: rtl/dpu_seq_ctrl_if.sv
// dpu_seq_ctrl_if: config/start/status bundle between the instruction decoder (master) and the DPU option sequencer (slave)
interface dpu_seq_ctrl_if #(
    parameter int NUM_STATES  = 4,
    parameter int DELAY_WIDTH = 8,
    parameter int ITER_WIDTH  = 8
);
    localparam int OPT_WIDTH = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1;

    logic                   cfg_valid;
    logic [OPT_WIDTH-1:0]   cfg_addr;
    logic [DELAY_WIDTH-1:0] cfg_delay;
    logic                   cfg_clr;
    logic                   cfg_err;
    logic                   start;
    logic [OPT_WIDTH:0]     start_len;
    logic [ITER_WIDTH-1:0]  start_iter;
    logic                   abort;
    logic                   busy;
    logic [OPT_WIDTH-1:0]   option;
    logic                   option_valid;
    logic                   acc_clear;
    logic                   done;

    modport master (
        output cfg_valid, cfg_addr, cfg_delay, cfg_clr, start, start_len, start_iter, abort,
        input  cfg_err, busy, option, option_valid, acc_clear, done
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_delay, cfg_clr, start, start_len, start_iter, abort,
        output cfg_err, busy, option, option_valid, acc_clear, done
    );
endinterface

// File: rtl/dpu_seq_ctrl.sv
// dpu_seq_ctrl: steps the DPU option index through a programmed dwell/clear table for N passes; DPU_SEQ_PERF_EN adds a busy-cycle counter
module dpu_seq_ctrl #(
    parameter int NUM_STATES  = 4,
    parameter int DELAY_WIDTH = 8,
    parameter int ITER_WIDTH  = 8
) (
    input logic            clk,
    input logic            rst_n,
    dpu_seq_ctrl_if.slave  bus
`ifdef DPU_SEQ_PERF_EN
    ,
    output logic [15:0]    perf_cycles
`endif
);
    localparam int OPT_WIDTH = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1;
    localparam logic [OPT_WIDTH:0] NS = (OPT_WIDTH+1)'(NUM_STATES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [DELAY_WIDTH-1:0] delay_tab [NUM_STATES];
    logic [NUM_STATES-1:0]  clr_tab;
    logic [DELAY_WIDTH-1:0] cnt;
    logic [ITER_WIDTH-1:0]  iter_left;
    logic [OPT_WIDTH-1:0]   last;
    logic [OPT_WIDTH-1:0]   last_in;
    logic [OPT_WIDTH-1:0]   nxt;
    logic [OPT_WIDTH:0]     len_eff;
    logic [DELAY_WIDTH-1:0] delay0;
    logic                   clr0;
    logic                   wr_idle;
    logic                   accept;

    // Clamp the requested length and forward a same-cycle entry-0 write into the first state
    always_comb begin
        wr_idle = bus.cfg_valid && state == IDLE && {1'b0, bus.cfg_addr} < NS;
        accept  = bus.start && state == IDLE;
        len_eff = bus.start_len == '0 ? (OPT_WIDTH+1)'(1) : bus.start_len > NS ? NS : bus.start_len;
        last_in = OPT_WIDTH'(len_eff - 1'b1);
        delay0  = wr_idle && bus.cfg_addr == '0 ? bus.cfg_delay : delay_tab[0];
        clr0    = wr_idle && bus.cfg_addr == '0 ? bus.cfg_clr : clr_tab[0];
        nxt     = bus.option + 1'b1;
    end

    // Option table: writable only while idle so a running sequence never sees a change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) delay_tab[i] <= '0;
            clr_tab <= '0;
        end else if (wr_idle) begin
            delay_tab[bus.cfg_addr] <= bus.cfg_delay;
            clr_tab[bus.cfg_addr]   <= bus.cfg_clr;
        end
    end

    // Sequencer FSM: dwell countdown per state, advance/wrap/finish, abort has priority over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            iter_left        <= '0;
            last             <= '0;
            bus.busy         <= 1'b0;
            bus.option       <= '0;
            bus.option_valid <= 1'b0;
            bus.acc_clear    <= 1'b0;
            bus.done         <= 1'b0;
            bus.cfg_err      <= 1'b0;
        end else begin
            bus.cfg_err   <= bus.cfg_valid && state != IDLE;
            bus.done      <= 1'b0;
            bus.acc_clear <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state            <= RUN;
                    last             <= last_in;
                    iter_left        <= bus.start_iter;
                    cnt              <= delay0;
                    bus.option       <= '0;
                    bus.option_valid <= 1'b1;
                    bus.busy         <= 1'b1;
                    bus.acc_clear    <= clr0;
                end
                RUN: if (bus.abort) begin
                    state            <= IDLE;
                    bus.option       <= '0;
                    bus.option_valid <= 1'b0;
                    bus.busy         <= 1'b0;
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (bus.option != last) begin
                    bus.option    <= nxt;
                    cnt           <= delay_tab[nxt];
                    bus.acc_clear <= clr_tab[nxt];
                end else if (iter_left != '0) begin
                    iter_left     <= iter_left - 1'b1;
                    bus.option    <= '0;
                    cnt           <= delay_tab[0];
                    bus.acc_clear <= clr_tab[0];
                end else begin
                    state            <= DONE;
                    bus.done         <= 1'b1;
                    bus.busy         <= 1'b0;
                    bus.option_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DPU_SEQ_PERF_EN
    // Busy-cycle counter: cleared on accepted start, saturating, frozen when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_cycles <= '0;
        else if (accept) perf_cycles <= '0;
        else if (bus.busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dpu_seq_ctrl.sv
// tb_dpu_seq_ctrl: vector table of runs checked against a per-cycle expected-output queue, plus abort/reject/reset sequences
module tb_dpu_seq_ctrl;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpu_seq_ctrl_if #(.NUM_STATES(NS), .DELAY_WIDTH(DW), .ITER_WIDTH(IW)) bus ();
`ifdef DPU_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    dpu_seq_ctrl #(.NUM_STATES(NS), .DELAY_WIDTH(DW), .ITER_WIDTH(IW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DPU_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    typedef struct packed {logic [1:0] opt; logic clr;} exp_t;
    typedef struct {logic [2:0] len; logic [7:0] iter; int cycles;} vec_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [7:0] m_delay [NS];
    logic m_clr [NS];
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_delay = d;
        bus.cfg_clr   = c;
        m_delay[a]    = d;
        m_clr[a]      = c;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("cfg_err_idle", bus.cfg_err, 0);
    endtask

    task automatic run_seq(input logic [2:0] len, input logic [7:0] iter, input int cycles,
                           input bit wr0, input logic [7:0] wd, input logic wc);
        int eff;
        int n;
        int cyc;
        exp_t e;
        @(negedge clk);
        if (wr0) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_addr  = '0;
            bus.cfg_delay = wd;
            bus.cfg_clr   = wc;
            m_delay[0]    = wd;
            m_clr[0]      = wc;
        end
        eff = len == 0 ? 1 : len > NS ? NS : int'(len);
        sb.delete();
        for (int p = 0; p <= int'(iter); p++)
            for (int s = 0; s < eff; s++)
                for (int c = 0; c <= int'(m_delay[s]); c++)
                    sb.push_back('{opt: 2'(s), clr: (c == 0) && m_clr[s]});
        bus.start      = 1'b1;
        bus.start_len  = len;
        bus.start_iter = iter;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        n   = 0;
        cyc = 1;
        while (!bus.done && cyc <= cycles + 4) begin
            chk("option_valid", bus.option_valid, 1);
            if (bus.option_valid) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("option", bus.option, e.opt);
                    chk("acc_clear", bus.acc_clear, e.clr);
                    chk("busy", bus.busy, 1);
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done", bus.done, 1);
        chk("done_cycle", cyc, cycles + 1);
        chk("busy_on_done", bus.busy, 0);
        chk("valid_on_done", bus.option_valid, 0);
        chk("valid_count", n, cycles);
        chk("sb_empty", sb.size(), 0);
`ifdef DPU_SEQ_PERF_EN
        chk("perf_cycles", perf_cycles, cycles);
`endif
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_delay  = '0;
        bus.cfg_clr    = 1'b0;
        bus.start      = 1'b0;
        bus.start_len  = '0;
        bus.start_iter = '0;
        bus.abort      = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_delay[i] = '0;
            m_clr[i]   = 1'b0;
        end
        vecs = '{'{3'd3, 8'd0, 6}, '{3'd3, 8'd1, 12}, '{3'd0, 8'd0, 3}, '{3'd7, 8'd0, 10},
                 '{3'd4, 8'd2, 30}, '{3'd1, 8'd1, 6}, '{3'd2, 8'd0, 4}};
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_option", bus.option, 0);
        chk("rst_valid", bus.option_valid, 0);
        chk("rst_acc_clear", bus.acc_clear, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        rst_n = 1'b1;

        cfg_write(0, 8'd2, 1'b1);
        cfg_write(1, 8'd0, 1'b0);
        cfg_write(2, 8'd1, 1'b0);
        cfg_write(3, 8'd3, 1'b0);
        for (int v = 0; v < 7; v++) run_seq(vecs[v].len, vecs[v].iter, vecs[v].cycles, 1'b0, 8'd0, 1'b0);

        // rejected write while busy, entry 1 must stay at delay 0
        @(negedge clk);
        bus.start = 1'b1; bus.start_len = 3'd3; bus.start_iter = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_delay = 8'd5; bus.cfg_clr = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("cfg_err_pulse", bus.cfg_err, 1);
        @(negedge clk);
        chk("cfg_err_single", bus.cfg_err, 0);
        for (int k = 0; k < 20 && !bus.done; k++) @(negedge clk);
        chk("rej_run_done", bus.done, 1);
        run_seq(3'd3, 8'd0, 6, 1'b0, 8'd0, 1'b0);

        // same-cycle entry-0 write and start: new delay 1, clr 0 applies
        run_seq(3'd1, 8'd0, 2, 1'b1, 8'd1, 1'b0);
        cfg_write(0, 8'd2, 1'b1);

        // abort in the 2nd cycle of state 1
        cfg_write(1, 8'd2, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.start_len = 3'd3; bus.start_iter = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_option", bus.option, 1);
        chk("pre_abort_busy", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_option", bus.option, 0);
        chk("abort_valid", bus.option_valid, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        chk("abort_no_done", bus.done, 0);
        cfg_write(1, 8'd0, 1'b0);
        run_seq(3'd3, 8'd0, 6, 1'b0, 8'd0, 1'b0);

        // maximum dwell
        cfg_write(0, 8'd255, 1'b1);
        run_seq(3'd1, 8'd0, 256, 1'b0, 8'd0, 1'b0);

        // asynchronous reset mid-dwell
        @(negedge clk);
        bus.start = 1'b1; bus.start_len = 3'd1; bus.start_iter = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_option", bus.option, 0);
        chk("arst_valid", bus.option_valid, 0);
        chk("arst_acc_clear", bus.acc_clear, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_cfg_err", bus.cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) begin
            m_delay[i] = '0;
            m_clr[i]   = 1'b0;
        end
        run_seq(3'd4, 8'd0, 4, 1'b0, 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
